// File: rtl/ame_num_normal_vec.sv
// Multi-lane two-stage sign-magnitude normaliser: |x| >> shift with optional
// round-half-away-from-zero, sign restore, narrow to OUT_BITS.
// Define AME_NORM_SAT_EN to saturate the narrowed result and report out_sat_o.
module ame_num_normal_vec #(
  parameter int unsigned LANES      = 4,
  parameter int unsigned DATA_BITS  = 64,
  parameter int unsigned OUT_BITS   = 32,
  parameter int unsigned SHIFT_BITS = $clog2(DATA_BITS)
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [SHIFT_BITS-1:0]      in_shift_i,
  input  logic                       in_round_i,
  input  logic [LANES*DATA_BITS-1:0] in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [LANES*OUT_BITS-1:0]  out_data_o,
  output logic [LANES-1:0]           out_sat_o
);

  logic                  s1_valid;
  logic                  s2_load;
  logic                  in_accept;

  logic [DATA_BITS-1:0]  s1_q [LANES];
  logic [LANES-1:0]      s1_sign;
  logic [LANES-1:0]      s1_rbit;

  logic [DATA_BITS-1:0]  s1_q_d [LANES];
  logic [LANES-1:0]      s1_sign_d;
  logic [LANES-1:0]      s1_rbit_d;

  logic [DATA_BITS-1:0]  lane_x;
  logic [DATA_BITS-1:0]  lane_a;
  logic [SHIFT_BITS-1:0] shift_m1;

  logic [DATA_BITS:0]    lane_m;
  logic [DATA_BITS:0]    lane_r;
  logic [LANES*OUT_BITS-1:0] s2_data_d;

  // Handshake: S2 accepts whenever its slot is empty or being drained.
  assign s2_load    = !out_valid_o || out_ready_i;
  assign in_ready_o = !flush_i && (!s1_valid || s2_load);
  assign in_accept  = in_valid_i && in_ready_o;

  // Stage 1: magnitude, shift and round bit per lane.
  always_comb begin
    shift_m1  = in_shift_i - SHIFT_BITS'(1);
    lane_x    = '0;
    lane_a    = '0;
    s1_sign_d = '0;
    s1_rbit_d = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_x       = in_data_i[l*DATA_BITS +: DATA_BITS];
      lane_a       = lane_x[DATA_BITS-1] ? (~lane_x + DATA_BITS'(1)) : lane_x;
      s1_sign_d[l] = lane_x[DATA_BITS-1];
      s1_q_d[l]    = lane_a >> in_shift_i;
      s1_rbit_d[l] = in_round_i && (in_shift_i != '0) && lane_a[shift_m1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (in_accept) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        s1_q[l] <= s1_q_d[l];
      end
      s1_sign <= s1_sign_d;
      s1_rbit <= s1_rbit_d;
    end
  end

`ifdef AME_NORM_SAT_EN
  logic [LANES-1:0]      s2_sat_d;
  logic [LANES-1:0]      sat_q;
  logic [DATA_BITS:OUT_BITS-1] lane_hi;

  // Stage 2: round, restore sign, clamp to the signed OUT_BITS range.
  always_comb begin
    lane_m    = '0;
    lane_r    = '0;
    lane_hi   = '0;
    s2_data_d = '0;
    s2_sat_d  = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_m  = {1'b0, s1_q[l]} + (DATA_BITS+1)'(s1_rbit[l]);
      lane_r  = s1_sign[l] ? (~lane_m + (DATA_BITS+1)'(1)) : lane_m;
      lane_hi = lane_r[DATA_BITS:OUT_BITS-1];
      if ((&lane_hi) || !(|lane_hi)) begin
        s2_data_d[l*OUT_BITS +: OUT_BITS] = lane_r[OUT_BITS-1:0];
      end else begin
        s2_sat_d[l] = 1'b1;
        s2_data_d[l*OUT_BITS +: OUT_BITS] = lane_r[DATA_BITS] ?
          {1'b1, {(OUT_BITS-1){1'b0}}} : {1'b0, {(OUT_BITS-1){1'b1}}};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sat_q <= '0;
    end else if (!flush_i && s2_load && s1_valid) begin
      sat_q <= s2_sat_d;
    end
  end

  assign out_sat_o = sat_q;
`else
  logic [LANES-1:0] wrap_unused;

  // Stage 2: round, restore sign, keep the low OUT_BITS (two's-complement wrap).
  always_comb begin
    lane_m      = '0;
    lane_r      = '0;
    s2_data_d   = '0;
    wrap_unused = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_m         = {1'b0, s1_q[l]} + (DATA_BITS+1)'(s1_rbit[l]);
      lane_r         = s1_sign[l] ? (~lane_m + (DATA_BITS+1)'(1)) : lane_m;
      wrap_unused[l] = ^lane_r[DATA_BITS:OUT_BITS-1];
      s2_data_d[l*OUT_BITS +: OUT_BITS] = lane_r[OUT_BITS-1:0];
    end
  end

  assign out_sat_o = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid    <= 1'b0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
    end else if (flush_i) begin
      s1_valid    <= 1'b0;
      out_valid_o <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid_o <= s1_valid;
      end
      if (s2_load && s1_valid) begin
        out_data_o <= s2_data_d;
      end
      if (in_accept) begin
        s1_valid <= 1'b1;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ame_num_normal_vec.sv
// Self-checking bench for ame_num_normal_vec: constant vector table, scripted
// stream/flush/reset sequences and a randomized run against a scoreboard model.
module tb_ame_num_normal_vec;

  localparam int LANES = 4;
  localparam int DB    = 64;
  localparam int OB    = 32;

  logic                  clk;
  logic                  rst_n;
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [5:0]            in_shift;
  logic                  in_round;
  logic [LANES*DB-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*OB-1:0]   out_data;
  logic [LANES-1:0]      out_sat;

  ame_num_normal_vec #(
    .LANES(LANES), .DATA_BITS(DB), .OUT_BITS(OB), .SHIFT_BITS(6)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_shift_i(in_shift), .in_round_i(in_round), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_sat_o(out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LANES*DB-1:0] d;
    logic [5:0]          sh;
    logic                rd;
    logic [LANES*OB-1:0] eo;
    logic [LANES-1:0]    es;
  } vec_t;

  typedef struct {
    logic [LANES*OB-1:0] d;
    logic [LANES-1:0]    s;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int drained = 0;
  exp_t sb[$];
  logic held = 1'b0;
  logic [LANES*OB-1:0] held_d;
  logic [LANES-1:0]    held_s;
  vec_t vt[8];

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MAX64 = 64'h7FFF_FFFF_FFFF_FFFF;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: |x| / 2^sh with remainder-based half-up rounding, then sign, then narrow.
  function automatic void model(input logic [LANES*DB-1:0] d, input logic [5:0] sh,
                                input logic rd, output exp_t e);
    logic [63:0] x;
    logic [66:0] mag, q, rem;
    logic up;
    logic signed [66:0] r;
    e.d = '0;
    e.s = '0;
    for (int l = 0; l < LANES; l++) begin
      x   = d[l*DB +: DB];
      mag = x[63] ? ((67'd1 << 64) - {3'b000, x}) : {3'b000, x};
      q   = mag >> sh;
      rem = mag - (q << sh);
      up  = rd && (sh != 6'd0) && ((rem << 1) >= (67'd1 << sh));
      q   = q + 67'(up);
      r   = x[63] ? -$signed(q) : $signed(q);
`ifdef AME_NORM_SAT_EN
      if (r > 67'sd2147483647) begin
        e.d[l*OB +: OB] = 32'h7FFF_FFFF; e.s[l] = 1'b1;
      end else if (r < -67'sd2147483648) begin
        e.d[l*OB +: OB] = 32'h8000_0000; e.s[l] = 1'b1;
      end else begin
        e.d[l*OB +: OB] = r[31:0];
      end
`else
      e.d[l*OB +: OB] = r[31:0];
`endif
    end
  endfunction

  function automatic logic [63:0] rnd64();
    longint t;
    logic [63:0] v;
    case ($urandom_range(0, 3))
      0: v = {$urandom, $urandom};
      1: begin t = longint'($urandom_range(0, 600)) - 300; v = t; end
      2: case ($urandom_range(0, 3))
           0: v = MIN64;
           1: v = MAX64;
           2: v = '0;
           default: v = '1;
         endcase
      default: begin t = longint'($signed($urandom)); v = t; end
    endcase
    return v;
  endfunction

  // One cycle with the scoreboard: drive at negedge, check #1 later, edge follows.
  task automatic step(input logic iv, input logic [LANES*DB-1:0] d, input logic [5:0] sh,
                      input logic rd, input logic ordy, input logic fl, output logic acc);
    exp_t e;
    @(negedge clk);
    in_valid = iv; in_data = d; in_shift = sh; in_round = rd;
    out_ready = ordy; flush = fl;
    #1;
    if (held) begin
      check("hold_valid", 128'(out_valid), 128'(1'b1));
      check("hold_data", 128'(out_data), 128'(held_d));
      check("hold_sat", 128'(out_sat), 128'(held_s));
    end
    check("in_ready", 128'(in_ready), 128'(!fl && !(sb.size() == 2 && !ordy)));
    if (sb.size() == 0) check("idle_valid", 128'(out_valid), 128'(1'b0));
    if (out_valid && ordy) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_beat actual=%h required=none t=%0t", out_data, $time);
      end else begin
        e = sb.pop_front();
        check("beat_data", 128'(out_data), 128'(e.d));
        check("beat_sat", 128'(out_sat), 128'(e.s));
        drained++;
      end
    end
    held   = out_valid && !ordy && !fl;
    held_d = out_data;
    held_s = out_sat;
    acc = iv && in_ready;
    if (acc) begin
      model(d, sh, rd, e);
      sb.push_back(e);
    end
    if (fl) sb.delete();
  endtask

  task automatic drain(input string nm);
    logic a;
    for (int i = 0; i < 12 && sb.size() != 0; i++) step(1'b0, '0, 6'd0, 1'b0, 1'b1, 1'b0, a);
    step(1'b0, '0, 6'd0, 1'b0, 1'b1, 1'b0, a);
    check(nm, 128'(sb.size()), 128'(0));
  endtask

  // Single isolated beat with fixed expected output and exact 2-cycle latency.
  task automatic run_vec(input string nm, input vec_t v);
    @(negedge clk);
    in_valid = 1'b1; in_data = v.d; in_shift = v.sh; in_round = v.rd;
    out_ready = 1'b1; flush = 1'b0;
    #1 check({nm, "_ready"}, 128'(in_ready), 128'(1'b1));
    @(negedge clk);
    in_valid = 1'b0;
    #1 check({nm, "_early"}, 128'(out_valid), 128'(1'b0));
    @(negedge clk);
    #1;
    check({nm, "_valid"}, 128'(out_valid), 128'(1'b1));
    check({nm, "_data"}, 128'(out_data), 128'(v.eo));
    check({nm, "_sat"}, 128'(out_sat), 128'(v.es));
    held = 1'b0;
  endtask

  initial begin
    logic a;
    logic [LANES*DB-1:0] d;
    int k, cyc;
    logic [3:0] pat;
    vec_t rv;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_shift = '0; in_round = 1'b0;
    in_data = '0; out_ready = 1'b0;

    vt[0] = '{ {64'd0, 64'd0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFB}, 6'd1, 1'b0,
               {32'd0, 32'd0, 32'd2, 32'hFFFF_FFFE}, 4'b0000 };
    vt[1] = '{ {64'd0, 64'd0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFB}, 6'd1, 1'b1,
               {32'd0, 32'd0, 32'd3, 32'hFFFF_FFFD}, 4'b0000 };
    vt[2] = '{ {64'hFFFF_FFFF_FFFF_FFFF, MAX64, 64'd5, MIN64}, 6'd63, 1'b0,
               {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF}, 4'b0000 };
    vt[3] = '{ {64'd0, 64'd0, MIN64, MAX64}, 6'd63, 1'b1,
               {32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1}, 4'b0000 };
    vt[4] = '{ {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC,
                64'hFFFF_FFFF_FFFF_FFFD, 64'd0}, 6'd3, 1'b1,
               {32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0}, 4'b0000 };
    vt[5] = '{ {64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd7}, 6'd0, 1'b1,
               {32'd0, 32'd0, 32'hFFFF_FFF9, 32'd7}, 4'b0000 };
`ifdef AME_NORM_SAT_EN
    vt[6] = '{ {64'd0, 64'd0, 64'd0, MIN64}, 6'd0, 1'b0,
               {32'd0, 32'd0, 32'd0, 32'h8000_0000}, 4'b0001 };
    vt[7] = '{ {64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000,
                64'h0000_0001_0000_0005, MAX64}, 6'd0, 1'b0,
               {32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF}, 4'b1011 };
`else
    vt[6] = '{ {64'd0, 64'd0, 64'd0, MIN64}, 6'd0, 1'b0,
               {32'd0, 32'd0, 32'd0, 32'd0}, 4'b0000 };
    vt[7] = '{ {64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000,
                64'h0000_0001_0000_0005, MAX64}, 6'd0, 1'b0,
               {32'h8000_0000, 32'h8000_0000, 32'd5, 32'hFFFF_FFFF}, 4'b0000 };
`endif

    #3;
    check("rst_out_valid", 128'(out_valid), 128'(1'b0));
    check("rst_in_ready", 128'(in_ready), 128'(1'b1));
    check("rst_out_data", 128'(out_data), 128'(0));
    check("rst_out_sat", 128'(out_sat), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vt[i]);
    drain("vec_drain");

    // Stream beats 1..8 under a 1,0,0,1 ready pattern.
    pat = 4'b1001; k = 1; cyc = 0; drained = 0;
    while (k <= 8 && cyc < 60) begin
      d = {4{64'(k)}};
      step(1'b1, d, 6'd0, 1'b0, pat[cyc % 4], 1'b0, a);
      if (a) k++;
      cyc++;
    end
    check("stream_accepted", 128'(k), 128'(9));
    for (int i = 0; i < 12 && sb.size() != 0; i++) begin
      step(1'b0, '0, 6'd0, 1'b0, pat[cyc % 4], 1'b0, a);
      cyc++;
    end
    drain("stream_drain");
    check("stream_count", 128'(drained), 128'(8));

    // Flush with two beats in flight and a beat offered alongside.
    step(1'b1, {4{64'd11}}, 6'd0, 1'b0, 1'b0, 1'b0, a);
    step(1'b1, {4{64'd12}}, 6'd0, 1'b0, 1'b0, 1'b0, a);
    check("flush_fill", 128'(sb.size()), 128'(2));
    step(1'b1, {4{64'd13}}, 6'd0, 1'b0, 1'b0, 1'b1, a);
    check("flush_no_accept", 128'(a), 128'(1'b0));
    step(1'b0, '0, 6'd0, 1'b0, 1'b1, 1'b0, a);
    drained = 0;
    step(1'b1, {4{64'd14}}, 6'd0, 1'b0, 1'b1, 1'b0, a);
    drain("flush_drain");
    check("flush_alone", 128'(drained), 128'(1));

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 400; i++) begin
      d = {rnd64(), rnd64(), rnd64(), rnd64()};
      step($urandom_range(0, 3) != 0, d, 6'($urandom_range(0, 63)), 1'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0, a);
    end
    drain("rand_drain");

    // Asynchronous reset between edges with a full pipeline.
    step(1'b1, {4{64'd21}}, 6'd0, 1'b0, 1'b0, 1'b0, a);
    step(1'b1, {4{64'd22}}, 6'd0, 1'b0, 1'b0, 1'b0, a);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 128'(out_valid), 128'(1'b0));
    check("arst_data", 128'(out_data), 128'(0));
    check("arst_sat", 128'(out_sat), 128'(0));
    sb.delete();
    held = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("arst_ready", 128'(in_ready), 128'(1'b1));
    rv = '{ {64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 6'd0, 1'b0,
            {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF}, 4'b0000 };
    run_vec("post_rst", rv);
    drain("post_rst_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
